// File: rtl/noc_endpoint.sv
// NoC endpoint: packs PE payloads into flits through a first-word-fall-through
// injection FIFO, and unpacks locally addressed flits into a one-deep ejection register.
module noc_endpoint #(
  parameter int DataWidth = 32,
  parameter int MyAddr    = 0,
  parameter int AddrMax   = 255,
  parameter int FifoDepth = 4
) (
  input  logic                 i_mclk,
  input  logic                 i_reset,
  input  logic [DataWidth-9:0] i_pe_data,
  input  logic [7:0]           i_pe_dest,
  input  logic                 i_pe_valid,
  output logic                 o_pe_ready,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  input  logic [DataWidth-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  output logic [DataWidth-9:0] o_pe_data,
  output logic                 o_pe_valid,
  input  logic                 i_pe_ready,
  output logic [15:0]          o_tx_cnt,
  output logic [15:0]          o_rx_cnt,
  output logic [15:0]          o_inj_drop_cnt,
  output logic [15:0]          o_misroute_cnt
);

  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  logic [DataWidth-1:0] fifo_mem [FifoDepth];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 fifo_full, fifo_empty, dest_ok, push, pop, inj_drop;

  assign fifo_full    = (count_reg == CW'(FifoDepth));
  assign fifo_empty   = (count_reg == '0);
  assign o_pe_ready   = ~fifo_full;
  assign o_data_valid = ~fifo_empty;
  assign o_data       = fifo_mem[rd_ptr_reg];

  // Nine-bit compare so AddrMax = 255 is a legal, never-rejecting setting.
  assign dest_ok  = ({1'b0, i_pe_dest} <= 9'(AddrMax));
  assign push     = i_pe_valid & ~fifo_full & dest_ok;
  assign inj_drop = i_pe_valid & ~fifo_full & ~dest_ok;
  assign pop      = ~fifo_empty & i_data_ready;

  always_ff @(posedge i_mclk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {i_pe_dest, i_pe_data};
  end

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  logic                 pe_valid_reg;
  logic [DataWidth-9:0] pe_data_reg;
  logic                 flit_acc, hdr_match, eject_take, misroute;

  assign o_data_ready = ~pe_valid_reg | i_pe_ready;
  assign flit_acc     = i_data_valid & o_data_ready;
  assign hdr_match    = (i_data[DataWidth-1 -: 8] == 8'(MyAddr));
  assign eject_take   = pe_valid_reg & i_pe_ready;
  assign misroute     = flit_acc & ~hdr_match;
  assign o_pe_valid   = pe_valid_reg;
  assign o_pe_data    = pe_data_reg;

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      pe_valid_reg <= 1'b0;
      pe_data_reg  <= '0;
    end else if (flit_acc & hdr_match) begin
      pe_valid_reg <= 1'b1;
      pe_data_reg  <= i_data[DataWidth-9:0];
    end else if (eject_take) begin
      pe_valid_reg <= 1'b0;
    end
  end

  // Saturating event counters: tx, rx, injection drop, misroute.
  logic [3:0]       cnt_inc;
  logic [3:0][15:0] cnt_val;

  assign cnt_inc = {misroute, inj_drop, eject_take, pop};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge i_mclk or posedge i_reset) begin
      if (i_reset)
        cnt_reg <= '0;
      else if (cnt_inc[gi] && cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
    assign cnt_val[gi] = cnt_reg;
  end

  assign o_tx_cnt       = cnt_val[0];
  assign o_rx_cnt       = cnt_val[1];
  assign o_inj_drop_cnt = cnt_val[2];
  assign o_misroute_cnt = cnt_val[3];

endmodule

// File: tb/tb_noc_endpoint.sv
// Bench for noc_endpoint: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based behavioural model.
module tb_noc_endpoint;
  localparam int DW = 32, MY = 3, AMAX = 15, DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [23:0]   pe_data_in;
  logic [7:0]    pe_dest_in;
  logic          pe_valid_in, pe_ready_out;
  logic [31:0]   data_out;
  logic          data_valid_out, data_ready_in;
  logic [31:0]   flit_in;
  logic          flit_valid_in, data_ready_out;
  logic [23:0]   pe_data_out;
  logic          pe_valid_out, pe_ready_in;
  logic [15:0]   tx_cnt, rx_cnt, drop_cnt, mis_cnt;

  always #5 clk = ~clk;

  noc_endpoint #(.DataWidth(DW), .MyAddr(MY), .AddrMax(AMAX), .FifoDepth(DEPTH)) dut (
    .i_mclk(clk), .i_reset(rst),
    .i_pe_data(pe_data_in), .i_pe_dest(pe_dest_in), .i_pe_valid(pe_valid_in),
    .o_pe_ready(pe_ready_out),
    .o_data(data_out), .o_data_valid(data_valid_out), .i_data_ready(data_ready_in),
    .i_data(flit_in), .i_data_valid(flit_valid_in), .o_data_ready(data_ready_out),
    .o_pe_data(pe_data_out), .o_pe_valid(pe_valid_out), .i_pe_ready(pe_ready_in),
    .o_tx_cnt(tx_cnt), .o_rx_cnt(rx_cnt), .o_inj_drop_cnt(drop_cnt), .o_misroute_cnt(mis_cnt)
  );

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: a queue of flits, one held payload, four counters.
  logic [31:0] mq[$];
  bit          m_pv;
  logic [23:0] m_pd;
  int          m_tx, m_rx, m_drop, m_mis;

  function automatic int sat(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  initial begin
    bit full, take, dready;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_pv = 0; m_pd = '0;
        m_tx = 0; m_rx = 0; m_drop = 0; m_mis = 0;
      end else begin
        full   = (mq.size() == DEPTH);
        take   = m_pv && pe_ready_in;
        dready = !m_pv || pe_ready_in;
        if (mq.size() > 0 && data_ready_in) begin
          void'(mq.pop_front());
          m_tx = sat(m_tx);
        end
        if (pe_valid_in && !full) begin
          if (int'(pe_dest_in) > AMAX) m_drop = sat(m_drop);
          else mq.push_back({pe_dest_in, pe_data_in});
        end
        if (take) m_rx = sat(m_rx);
        if (flit_valid_in && dready && int'(flit_in[31:24]) == MY) begin
          m_pd = flit_in[23:0];
          m_pv = 1;
        end else begin
          if (flit_valid_in && dready) m_mis = sat(m_mis);
          if (take) m_pv = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pe_ready",   32'(pe_ready_out),   32'(mq.size() < DEPTH));
      chk("data_valid", 32'(data_valid_out), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("data", data_out, mq[0]);
      chk("data_ready", 32'(data_ready_out), 32'(!m_pv || pe_ready_in));
      chk("pe_valid",   32'(pe_valid_out),   32'(m_pv));
      chk("pe_data",    32'(pe_data_out),    32'(m_pd));
      chk("tx_cnt",     32'(tx_cnt),         32'(m_tx));
      chk("rx_cnt",     32'(rx_cnt),         32'(m_rx));
      chk("drop_cnt",   32'(drop_cnt),       32'(m_drop));
      chk("mis_cnt",    32'(mis_cnt),        32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic first_push();
    pe_valid_in = 1; pe_data_in = 24'h00ABCD; pe_dest_in = 8'h05; data_ready_in = 1;
    step();
    chk("s1_data", data_out, 32'h0500ABCD);
    chk("s1_valid", 32'(data_valid_out), 32'd1);
    chk("s1_tx0", 32'(tx_cnt), 32'd0);
    pe_valid_in = 0;
    step();
    chk("s1_empty", 32'(data_valid_out), 32'd0);
    chk("s1_tx1", 32'(tx_cnt), 32'd1);
  endtask

  initial begin
    pe_data_in = '0; pe_dest_in = '0; pe_valid_in = 0; data_ready_in = 0;
    flit_in = '0; flit_valid_in = 0; pe_ready_in = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_data_valid", 32'(data_valid_out), 32'd0);
    chk("rst_pe_ready", 32'(pe_ready_out), 32'd1);
    chk("rst_pe_valid", 32'(pe_valid_out), 32'd0);
    chk("rst_pe_data", 32'(pe_data_out), 32'd0);
    chk("rst_cnts", {tx_cnt, mis_cnt}, 32'd0);

    first_push();

    // Fill with the switch stalled, hold off a fifth word, then drain.
    data_ready_in = 0;
    for (int i = 0; i < 4; i++) begin
      pe_valid_in = 1; pe_dest_in = 8'h01; pe_data_in = 24'h000100 + 24'(i);
      step();
    end
    chk("full_ready", 32'(pe_ready_out), 32'd0);
    chk("full_head", data_out, 32'h01000100);
    pe_data_in = 24'h000105;
    step();
    chk("held_ready", 32'(pe_ready_out), 32'd0);
    chk("held_head", data_out, 32'h01000100);
    data_ready_in = 1;
    step();
    chk("pop1_head", data_out, 32'h01000101);
    chk("pop1_ready", 32'(pe_ready_out), 32'd1);
    step();
    chk("pushpop_head", data_out, 32'h01000102);
    pe_valid_in = 0;
    step();
    chk("drain_103", data_out, 32'h01000103);
    step();
    chk("drain_105", data_out, 32'h01000105);
    step();
    chk("drain_empty", 32'(data_valid_out), 32'd0);
    chk("drain_tx", 32'(tx_cnt), 32'd6);

    // Out-of-range destination is rejected.
    pe_valid_in = 1; pe_dest_in = 8'h20; pe_data_in = 24'h000777;
    step();
    pe_valid_in = 0;
    chk("drop_valid", 32'(data_valid_out), 32'd0);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);

    // Back-to-back ejection with one misrouted flit in the middle.
    pe_ready_in = 1; flit_valid_in = 1; flit_in = 32'h03000011;
    step();
    chk("ej_11", 32'(pe_data_out), 32'h11);
    chk("ej_11v", 32'(pe_valid_out), 32'd1);
    flit_in = 32'h07000022;
    step();
    chk("ej_mis_v", 32'(pe_valid_out), 32'd0);
    chk("ej_mis_cnt", 32'(mis_cnt), 32'd1);
    flit_in = 32'h03000033;
    step();
    chk("ej_33", 32'(pe_data_out), 32'h33);
    flit_valid_in = 0;
    step();
    chk("ej_rx2", 32'(rx_cnt), 32'd2);
    chk("ej_idle_v", 32'(pe_valid_out), 32'd0);

    // PE stall holds the payload; release with a new flit on the same edge.
    pe_ready_in = 0; flit_valid_in = 1; flit_in = 32'h03000044;
    step();
    flit_in = 32'h03000055;
    #1;
    chk("stall_dready", 32'(data_ready_out), 32'd0);
    step();
    step();
    chk("stall_data", 32'(pe_data_out), 32'h44);
    pe_ready_in = 1;
    step();
    chk("reload_v", 32'(pe_valid_out), 32'd1);
    chk("reload_d", 32'(pe_data_out), 32'h55);
    flit_valid_in = 0;
    step();
    chk("reload_rx", 32'(rx_cnt), 32'd4);

    // Asynchronous reset with buffered flits and a held payload.
    data_ready_in = 0; pe_ready_in = 0;
    pe_valid_in = 1; pe_dest_in = 8'h02; pe_data_in = 24'h000201;
    flit_valid_in = 1; flit_in = 32'h03000066;
    step();
    pe_data_in = 24'h000202; flit_valid_in = 0;
    step();
    pe_valid_in = 0;
    chk("pre_rst_dv", 32'(data_valid_out), 32'd1);
    chk("pre_rst_pv", 32'(pe_valid_out), 32'd1);
    #1 rst = 1;
    #1;
    chk("arst_dv", 32'(data_valid_out), 32'd0);
    chk("arst_pv", 32'(pe_valid_out), 32'd0);
    chk("arst_pd", 32'(pe_data_out), 32'd0);
    chk("arst_cnt", {tx_cnt, rx_cnt}, 32'd0);
    chk("arst_cnt2", {drop_cnt, mis_cnt}, 32'd0);
    chk("arst_ready", 32'(pe_ready_out), 32'd1);
    #3 rst = 0;
    first_push();

    // Random traffic on both paths with one mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1;
        #1 rst = 0;
      end
      pe_valid_in   = ($urandom_range(0, 2) != 0);
      pe_data_in    = 24'($urandom);
      pe_dest_in    = 8'($urandom_range(0, 20));
      data_ready_in = ($urandom_range(0, 3) != 0);
      flit_valid_in = ($urandom_range(0, 1) != 0);
      flit_in       = {(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(MY)), 24'($urandom)};
      pe_ready_in   = ($urandom_range(0, 2) != 0);
      step();
    end

    pe_valid_in = 0; flit_valid_in = 0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
